// File: rtl/rr_mux_sequencer.sv
// Round-robin sequencer for a 4:1 byte mux: picks a requesting source, drives the
// mux select, captures the settled mux output and hands it downstream via valid/ready.
module rr_mux_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_data,
    input  logic             out_ready,
    output logic [1:0]       select,
    output logic [3:0]       grant,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, SEL, OUT} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       last_ptr_reg, last_ptr_next;
    logic [1:0]       select_reg, select_next;
    logic [3:0]       grant_reg, grant_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic [CNT_W-1:0] word_count_reg, word_count_next;

    logic [1:0] start;
    logic [3:0] req_rot;
    logic [3:0] sel_onehot;
    logic [1:0] pick_offset;
    logic [1:0] pick;

    // Rotate req so bit 0 is the source just after the last winner; 2-bit sums wrap mod 4.
    assign start = last_ptr_reg + 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi]    = req[start + 2'(gi)];
            assign sel_onehot[gi] = (select_reg == 2'(gi));
        end
    endgenerate

    always_comb begin
        pick_offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) pick_offset = 2'(i);
        end
    end

    assign pick = start + pick_offset;

    always_comb begin
        state_next      = state_reg;
        last_ptr_next   = last_ptr_reg;
        select_next     = select_reg;
        grant_next      = 4'b0000;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        word_count_next = word_count_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    select_next   = pick;
                    last_ptr_next = pick;
                    state_next    = SEL;
                end
            end
            SEL: begin
                // req is deliberately not rechecked: the selected word is captured regardless.
                out_data_next  = mux_data;
                out_valid_next = 1'b1;
                grant_next     = sel_onehot;
                state_next     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_next  = 1'b0;
                    word_count_next = word_count_reg + CNT_W'(1);
                    if (|req) begin
                        select_next   = pick;
                        last_ptr_next = pick;
                        state_next    = SEL;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_ptr_reg   <= 2'd3;
            select_reg     <= 2'd0;
            grant_reg      <= 4'b0000;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            word_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            last_ptr_reg   <= last_ptr_next;
            select_reg     <= select_next;
            grant_reg      <= grant_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            word_count_reg <= word_count_next;
        end
    end

    assign select     = select_reg;
    assign grant      = grant_reg;
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_rr_mux_sequencer.sv
// Bench for rr_mux_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model (pending capture / held word / round-robin pointer).
module tb_rr_mux_sequencer;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [W-1:0]  mux_data;
    logic          out_ready;
    logic [1:0]    select;
    logic [3:0]    grant;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [CW-1:0] word_count;

    logic [W-1:0]  mux_in [4];

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int            m_ptr;
    logic [1:0]    m_sel;
    bit            m_pend;
    bit            m_valid;
    logic [W-1:0]  m_data;
    logic [CW-1:0] m_count;
    logic [3:0]    m_grant;

    rr_mux_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .mux_data(mux_data), .out_ready(out_ready),
        .select(select), .grant(grant), .out_data(out_data), .out_valid(out_valid),
        .word_count(word_count)
    );

    always #5 clk = ~clk;
    always_comb mux_data = mux_in[select];

    function automatic int rr_pick(logic [3:0] r, int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Advance model and DUT by one clock; outputs are stable 1ns after the edge.
    task automatic tick();
        int            p;
        logic [1:0]    n_sel   = m_sel;
        int            n_ptr   = m_ptr;
        bit            n_pend  = m_pend;
        bit            n_valid = m_valid;
        logic [W-1:0]  n_data  = m_data;
        logic [CW-1:0] n_count = m_count;
        logic [3:0]    n_grant = 4'b0000;
        if (rst) begin
            n_sel = 2'd0; n_ptr = 3; n_pend = 0; n_valid = 0; n_data = '0; n_count = '0;
        end else if (m_pend) begin
            n_data = mux_in[m_sel]; n_valid = 1; n_grant = 4'b0001 << m_sel; n_pend = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                n_valid = 0;
                n_count = m_count + 1'b1;
                p = rr_pick(req, m_ptr);
                if (p >= 0) begin n_sel = 2'(p); n_ptr = p; n_pend = 1; end
            end
        end else begin
            p = rr_pick(req, m_ptr);
            if (p >= 0) begin n_sel = 2'(p); n_ptr = p; n_pend = 1; end
        end
        @(posedge clk);
        #1;
        m_sel = n_sel; m_ptr = n_ptr; m_pend = n_pend; m_valid = n_valid;
        m_data = n_data; m_count = n_count; m_grant = n_grant;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_mux_default();
        mux_in[0] = 8'haa; mux_in[1] = 8'hbb; mux_in[2] = 8'hcc; mux_in[3] = 8'hdd;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (select !== 2'd0) begin n_err++; $display("FAIL reset_select: got %0d expected 0", select); end
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (word_count !== 4'd0) begin n_err++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    endtask

    task automatic test_single();
        set_mux_default();
        req = 4'b0001; out_ready = 1'b1;
        tick();
        n_cmp++; if (select !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_n1: got select=%0d valid=%b expected select=0 valid=0", select, out_valid); end
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b expected 0001", grant); end
        n_cmp++; if (out_data !== 8'haa || out_valid !== 1'b1) begin n_err++; $display("FAIL single_data: got %h/%b expected aa/1", out_data, out_valid); end
        req = 4'b0000;
        tick();
        n_cmp++; if (word_count !== 4'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_count: got count=%0d valid=%b expected count=1 valid=0", word_count, out_valid); end
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_grant_pulse: got %b expected 0000", grant); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] exp_d [5] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'haa};
        logic [3:0]   qg [$];
        logic [W-1:0] qd [$];
        do_reset();
        set_mux_default();
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (grant !== m_grant || out_data !== m_data) begin n_err++; $display("FAIL b2b_cycle%0d: got grant=%b data=%h expected grant=%b data=%h", c, grant, out_data, m_grant, m_data); end
            if (grant != 4'b0000) begin qg.push_back(grant); qd.push_back(out_data); end
        end
        n_cmp++; if (qg.size() != 5) begin n_err++; $display("FAIL b2b_count: got %0d grants expected 5", qg.size()); end
        for (int i = 0; i < 5 && i < qg.size(); i++) begin
            n_cmp++; if (qg[i] !== exp_g[i] || qd[i] !== exp_d[i]) begin n_err++; $display("FAIL b2b_word%0d: got %b/%h expected %b/%h", i, qg[i], qd[i], exp_g[i], exp_d[i]); end
        end
    endtask

    task automatic test_pair();
        logic [3:0]   exp_g [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        logic [W-1:0] exp_d [4] = '{8'hdd, 8'hbb, 8'hdd, 8'hbb};
        logic [3:0]   qg [$];
        logic [W-1:0] qd [$];
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL pair_first: got %b expected 0010", grant); end
        req = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (grant != 4'b0000) begin qg.push_back(grant); qd.push_back(out_data); end
        end
        n_cmp++; if (qg.size() != 4) begin n_err++; $display("FAIL pair_count: got %0d grants expected 4", qg.size()); end
        for (int i = 0; i < 4 && i < qg.size(); i++) begin
            n_cmp++; if (qg[i] !== exp_g[i] || qd[i] !== exp_d[i]) begin n_err++; $display("FAIL pair_word%0d: got %b/%h expected %b/%h", i, qg[i], qd[i], exp_g[i], exp_d[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b0001; out_ready = 1'b0;
        tick(); tick();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (out_data !== 8'haa || out_valid !== 1'b1 || select !== 2'd0) begin n_err++; $display("FAIL stall_hold%0d: got data=%h valid=%b sel=%0d expected aa/1/0", c, out_data, out_valid, select); end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (select !== 2'd2 || word_count !== m_count) begin n_err++; $display("FAIL stall_release: got sel=%0d count=%0d expected sel=2 count=%0d", select, word_count, m_count); end
        tick();
        n_cmp++; if (grant !== 4'b0100 || out_data !== 8'hcc) begin n_err++; $display("FAIL stall_next: got %b/%h expected 0100/cc", grant, out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (out_data !== 8'hbb || out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %h/%b expected bb/1", out_data, out_valid); end
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || grant !== 4'b0000 || word_count !== 4'd0) begin n_err++; $display("FAIL rstmid_post: got valid=%b data=%h grant=%b count=%0d expected 0/00/0000/0", out_valid, out_data, grant, word_count); end
        req = 4'b0110; out_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (grant !== 4'b0010 || out_data !== 8'hbb) begin n_err++; $display("FAIL rstmid_first: got %b/%h expected 0010/bb", grant, out_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 31) begin
                n_cmp++; if (word_count !== 4'd15) begin n_err++; $display("FAIL wrap_pre: got %0d expected 15", word_count); end
            end
        end
        n_cmp++; if (word_count !== 4'd0) begin n_err++; $display("FAIL wrap_zero: got %0d expected 0", word_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) mux_in[i] = 8'($urandom);
            tick();
            n_cmp++;
            if (select !== m_sel || grant !== m_grant || out_data !== m_data ||
                out_valid !== m_valid || word_count !== m_count) begin
                n_err++;
                $display("FAIL rand_cycle%0d: got sel=%0d g=%b d=%h v=%b n=%0d expected sel=%0d g=%b d=%h v=%b n=%0d",
                         c, select, grant, out_data, out_valid, word_count,
                         m_sel, m_grant, m_data, m_valid, m_count);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        m_ptr = 3; m_sel = 2'd0; m_pend = 0; m_valid = 0; m_data = '0; m_count = '0; m_grant = 4'b0000;
        set_mux_default();
        test_reset();
        test_single();
        test_back_to_back();
        test_pair();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
